// File: rtl/data_memory.sv
// Data-memory responder for the RV32I MEM stage: one byte/half/word access at a
// time over a fixed busy latency, sign/zero-extended loads, one-cycle done.
module data_memory #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSYWAIT,
  output logic        ERROR
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam int AW = ADDR_BITS + 2;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rd_q, wr_q;
  logic [2:0]      f3_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;

  logic [31:0]     mem [0:(1 << ADDR_BITS) - 1];

  logic            req;
  logic            busy;
  logic            capture;
  logic            complete;

  logic            op_rd, op_wr;
  logic [2:0]      op_f3;
  logic [AW-1:0]   op_addr;
  logic [31:0]     op_wdata;
  logic            op_err;

  logic [31:0]     rd_word;
  logic [31:0]     rd_lane;
  logic [31:0]     load_val;
  logic [3:0]      byte_en;
  logic [31:0]     wr_lanes;

  logic            unused_addr_hi;

  assign unused_addr_hi = ^ADDRESS[31:AW];
  assign req            = MEM_READ | MEM_WRITE;

  // With LATENCY=1 the access completes on the edge leaving IDLE, so the
  // operands come straight from the ports in that state.
  always_comb begin
    if (state_q == IDLE) begin
      op_rd    = MEM_READ;
      op_wr    = MEM_WRITE;
      op_f3    = FUNCT3;
      op_addr  = ADDRESS[AW-1:0];
      op_wdata = WRITE_DATA;
    end else begin
      op_rd    = rd_q;
      op_wr    = wr_q;
      op_f3    = f3_q;
      op_addr  = addr_q;
      op_wdata = wdata_q;
    end
  end

  always_comb begin
    op_err = 1'b0;
    if (op_rd && op_wr)                                  op_err = 1'b1;
    if (op_f3 == 3'b011 || op_f3[2:1] == 2'b11)          op_err = 1'b1;
    if (op_wr && op_f3[2])                               op_err = 1'b1;
    if (op_f3[1:0] == 2'b01 && op_addr[0])               op_err = 1'b1;
    if (op_f3[1:0] == 2'b10 && op_addr[1:0] != 2'b00)    op_err = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    capture  = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        busy = req;
        if (req) begin
          capture = 1'b1;
          if (LATENCY == 1) begin
            complete = 1'b1;
            state_d  = DONE;
          end else begin
            state_d = ACCESS;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      ACCESS: begin
        busy = 1'b1;
        if (cnt_q <= CW'(1)) begin
          complete = 1'b1;
          state_d  = DONE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (RESET) begin
      busy     = 1'b0;
      complete = 1'b0;
    end
  end

  assign BUSYWAIT = busy;

  always_comb begin
    rd_word = mem[op_addr[AW-1:2]];
    rd_lane = rd_word >> {op_addr[1:0], 3'b000};
    case (op_f3[1:0])
      2'b00:   load_val = op_f3[2] ? {24'b0, rd_lane[7:0]}
                                   : {{24{rd_lane[7]}}, rd_lane[7:0]};
      2'b01:   load_val = op_f3[2] ? {16'b0, rd_lane[15:0]}
                                   : {{16{rd_lane[15]}}, rd_lane[15:0]};
      default: load_val = rd_word;
    endcase
  end

  always_comb begin
    byte_en  = '1;
    wr_lanes = op_wdata;
    case (op_f3[1:0])
      2'b00: begin
        byte_en  = 4'b0001 << op_addr[1:0];
        wr_lanes = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        byte_en  = op_addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{op_wdata[15:0]}};
      end
      default: begin
        byte_en  = '1;
        wr_lanes = op_wdata;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      f3_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      READ_DATA <= '0;
      ERROR     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        rd_q    <= MEM_READ;
        wr_q    <= MEM_WRITE;
        f3_q    <= FUNCT3;
        addr_q  <= ADDRESS[AW-1:0];
        wdata_q <= WRITE_DATA;
      end
      ERROR <= complete & op_err;
      if (complete) begin
        if (op_err)     READ_DATA <= '0;
        else if (op_rd) READ_DATA <= load_val;
      end
    end
  end

  // Array is deliberately not reset; only completed legal stores touch it.
  always_ff @(posedge CLK) begin
    if (complete && op_wr && !op_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[op_addr[AW-1:2]][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed accesses against a word-array
// model, cycle-by-cycle output comparison plus literal expectations.
module tb_data_memory;

  localparam int AB  = 10;
  localparam int LAT = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [2:0]  FUNCT3;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSYWAIT;
  logic        ERROR;

  always #5 CLK = ~CLK;

  data_memory #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .MEM_READ  (MEM_READ),
    .MEM_WRITE (MEM_WRITE),
    .FUNCT3    (FUNCT3),
    .ADDRESS   (ADDRESS),
    .WRITE_DATA(WRITE_DATA),
    .READ_DATA (READ_DATA),
    .BUSYWAIT  (BUSYWAIT),
    .ERROR     (ERROR)
  );

  int          checks   = 0;
  int          failures = 0;
  bit          chk_en   = 1'b0;
  logic        exp_busy = 1'b0;
  logic        exp_err  = 1'b0;
  logic [31:0] exp_rd   = '0;
  logic [31:0] mm [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("busywait", 32'(BUSYWAIT), 32'(exp_busy));
      check("error", 32'(ERROR), 32'(exp_err));
      check("read_data", READ_DATA, exp_rd);
    end
  end

  function automatic bit m_err(input bit rd, input bit wr, input logic [2:0] f3,
                               input logic [31:0] addr);
    if (rd && wr) return 1'b1;
    case (f3)
      3'b000:  return 1'b0;
      3'b001:  return addr[0];
      3'b010:  return addr[1:0] != 2'b00;
      3'b100:  return wr;
      3'b101:  return wr || addr[0];
      default: return 1'b1;
    endcase
  endfunction

  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit hold, input bit use_lit,
                        input logic [31:0] lit_rd, input bit lit_err);
    bit          e;
    int          idx;
    int          sh;
    logic [31:0] w;
    logic [31:0] v;
    @(posedge CLK); #1;
    MEM_READ   = rd;
    MEM_WRITE  = wr;
    FUNCT3     = f3;
    ADDRESS    = addr;
    WRITE_DATA = wdata;
    exp_busy   = 1'b1;
    exp_err    = 1'b0;
    repeat (LAT - 1) begin
      @(posedge CLK); #1;
      MEM_READ   = $urandom_range(0, 1);
      WRITE_DATA = $urandom;
      MEM_READ   = rd;
      WRITE_DATA = wdata;
    end
    @(posedge CLK); #1;
    e   = m_err(rd, wr, f3, addr);
    idx = int'(addr[AB+1:2]);
    w   = mm.exists(idx) ? mm[idx] : 'x;
    if (e) begin
      exp_rd = '0;
    end else if (wr) begin
      case (f3)
        3'b000: begin sh = int'(addr[1:0]) * 8;  w[sh +: 8]  = wdata[7:0];  end
        3'b001: begin sh = int'(addr[1]) * 16;   w[sh +: 16] = wdata[15:0]; end
        default: w = wdata;
      endcase
      mm[idx] = w;
    end else begin
      case (f3[1:0])
        2'b00: begin
          v = (w >> (int'(addr[1:0]) * 8)) & 32'hFF;
          exp_rd = (!f3[2] && v[7]) ? (v | 32'hFFFF_FF00) : v;
        end
        2'b01: begin
          v = (w >> (int'(addr[1]) * 16)) & 32'hFFFF;
          exp_rd = (!f3[2] && v[15]) ? (v | 32'hFFFF_0000) : v;
        end
        default: exp_rd = w;
      endcase
    end
    exp_busy = 1'b0;
    exp_err  = e;
    if (use_lit) begin
      check("lit_read_data", READ_DATA, lit_rd);
      check("lit_error", 32'(ERROR), 32'(lit_err));
    end
    if (!hold) begin
      MEM_READ  = 1'b0;
      MEM_WRITE = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
      MEM_READ  = 1'b0;
      MEM_WRITE = 1'b0;
      exp_busy  = 1'b0;
      exp_err   = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; MEM_READ = 1'b1; MEM_WRITE = 1'b0;
    FUNCT3 = 3'b010; ADDRESS = '0; WRITE_DATA = '0;
    @(posedge CLK); #1;
    chk_en = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0; MEM_READ = 1'b0;
    idle(1);

    // word, byte and halfword lanes
    access(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, '0, 0);
    access(1, 0, 3'b010, 32'h10, '0, 0, 1, 32'hDEADBEEF, 0);
    access(0, 1, 3'b000, 32'h11, 32'hFFFFFF5A, 0, 0, '0, 0);
    access(1, 0, 3'b010, 32'h10, '0, 0, 1, 32'hDEAD5AEF, 0);
    access(0, 1, 3'b000, 32'h13, 32'h00000080, 0, 0, '0, 0);
    access(1, 0, 3'b000, 32'h13, '0, 0, 1, 32'hFFFFFF80, 0);
    access(1, 0, 3'b100, 32'h13, '0, 0, 1, 32'h00000080, 0);
    access(0, 1, 3'b001, 32'h12, 32'hABCD9234, 0, 0, '0, 0);
    access(1, 0, 3'b010, 32'h10, '0, 0, 1, 32'h92345AEF, 0);
    access(1, 0, 3'b001, 32'h12, '0, 0, 1, 32'hFFFF9234, 0);
    access(1, 0, 3'b101, 32'h12, '0, 0, 1, 32'h00009234, 0);
    access(1, 0, 3'b001, 32'h10, '0, 0, 1, 32'h00005AEF, 0);
    idle(2);

    // illegal accesses
    access(1, 0, 3'b010, 32'h12, '0, 0, 1, 32'h0, 1);
    access(0, 1, 3'b010, 32'h13, 32'h0, 0, 1, 32'h0, 1);
    access(1, 0, 3'b010, 32'h10, '0, 0, 1, 32'h92345AEF, 0);
    access(1, 1, 3'b010, 32'h10, 32'h0, 0, 1, 32'h0, 1);
    access(1, 0, 3'b011, 32'h10, '0, 0, 1, 32'h0, 1);
    access(0, 1, 3'b100, 32'h10, 32'h1, 0, 1, 32'h0, 1);
    access(1, 0, 3'b101, 32'h11, '0, 0, 1, 32'h0, 1);
    access(1, 0, 3'b010, 32'h10, '0, 0, 1, 32'h92345AEF, 0);

    // READ_DATA holds across stores
    access(1, 0, 3'b000, 32'h10, '0, 0, 1, 32'hFFFFFFEF, 0);
    access(0, 1, 3'b010, 32'h14, 32'h12345678, 0, 1, 32'hFFFFFFEF, 0);
    idle(1);

    // reset during the second busy cycle of a store
    access(0, 1, 3'b010, 32'h20, 32'h22222222, 0, 0, '0, 0);
    @(posedge CLK); #1;
    MEM_WRITE = 1'b1; MEM_READ = 1'b0; FUNCT3 = 3'b010;
    ADDRESS = 32'h20; WRITE_DATA = 32'h11111111;
    exp_busy = 1'b1; exp_err = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1; exp_busy = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0; MEM_WRITE = 1'b0;
    exp_rd = '0;
    access(1, 0, 3'b010, 32'h20, '0, 0, 1, 32'h22222222, 0);

    // address aliasing and back-to-back held requests
    access(0, 1, 3'b010, 32'h1004, 32'hCAFEF00D, 0, 0, '0, 0);
    access(1, 0, 3'b010, 32'h4, '0, 0, 1, 32'hCAFEF00D, 0);
    access(1, 0, 3'b010, 32'h10, '0, 1, 1, 32'h92345AEF, 0);
    access(1, 0, 3'b010, 32'h10, '0, 1, 1, 32'h92345AEF, 0);
    access(1, 0, 3'b010, 32'h10, '0, 0, 1, 32'h92345AEF, 0);
    idle(3);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
